maxfinder_loader: RTL
=====================

Name: maxfinder_loader

Overview:
- Upstream stage of the maxfinder datapath. Accepts a valid/ready stream of 4-bit samples and writes them into a 16-entry sample memory.
- Serves the datapath's combinational reads: the datapath's `addr` drives `rd_addr`; `rd_data` drives the datapath's `din`.
- Issues a one-cycle `start` to the maxfinder controller when a full frame of LASTADDR+1 samples is stored.
- Waits for the controller's `done` before the frame's storage is reused.

Parameters:
- WIDTH, 4, sample width in bits (matches datapath `din`/`max`).
- AW, 4, address width (matches datapath `addr`).
- LASTADDR, 4'hf, last address of a frame; frame length = LASTADDR+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_data  in  WIDTH  upstream sample
- in_ready  out  1  loader can accept a sample this cycle
- rd_addr  in  AW  read address from datapath `addr`
- rd_data  out  WIDTH  sample at rd_addr in the active search bank; combinational read
- start  out  1  one-cycle pulse: frame ready, begin search
- done  in  1  controller has finished the search of the current frame
- busy  out  1  a search is in progress (between start and done)

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- Handshake: a sample transfers on a rising edge with in_valid && in_ready. in_ready = !full[wr_bank], combinational from registers only, never from in_valid.
- Write: an accepted sample goes to mem[wr_bank][wr_ptr], then wr_ptr increments.
- Frame complete: on an accepted write with wr_ptr == LASTADDR:
  - wr_ptr wraps to 0;
  - full[wr_bank] is set;
  - wr_bank toggles (ping-pong build only).
- Search FSM, states IDLE and SEARCH:
  - IDLE -> SEARCH when full[rd_bank] is set. start is a registered pulse, high for exactly the first cycle of SEARCH.
  - SEARCH -> IDLE on done: full[rd_bank] clears; rd_bank toggles (ping-pong build only).
  - busy = (state == SEARCH).
- Latency: last accepted sample at edge N -> start high during cycle N+1 (earliest case, searcher idle).
- done in IDLE is ignored. done on the same cycle start is high is honoured (zero-length search).
- Simultaneous last write and done on the same bank (single-bank build only): cannot occur, since in_ready is 0 while the bank is full.
- Simultaneous done and last write on different banks (ping-pong): both take effect in the same cycle; the next start follows one cycle later if the other bank is full.
- in_valid held high with in_ready low: no write, no pointer change; in_data is don't-care.
- rd_data reflects memory contents combinationally. Reading mid-fill gives stale data; this is legal and not checked.
- Reset values: state = IDLE, start = 0, busy = 0, wr_ptr = 0, wr_bank = 0, rd_bank = 0, all full flags = 0, so in_ready = 1 after reset.
- Memory contents are not reset.
- Reset mid-fill or mid-search: the partial frame is discarded and the loader restarts clean. The controller is reset by the same signal.

Optional Feature:
- MAXFINDER_LOADER_PINGPONG_EN
- Defined: two memory banks (2 x 16 x WIDTH) with wr_bank/rd_bank toggle bits. The next frame fills while the current one is searched, so in_ready stays high during SEARCH unless both banks are full.
- Undefined: a single bank. wr_bank and rd_bank are tied to 0, and in_ready is 0 from the frame-complete edge until done.
- The port list is identical in both builds.

Decomposition:
- Shared package maxfinder_pkg holds:
  - WIDTH and AW defaults;
  - the LASTADDR default;
  - the search-state encoding (IDLE = 1'b0, SEARCH = 1'b1).
- One sub-module, maxfinder_sample_ram: 16 x WIDTH register file with one synchronous write port and one combinational read port. It is instantiated once, or twice under the ping-pong macro; the top muxes rd_data by rd_bank.
- The FSM and pointers stay in the top level.

Test Plan:
- Reset then stream samples 0..15 with in_valid held high -> 16 accepts on consecutive edges; start high exactly one cycle after the 16th; busy=1; rd_addr=7 gives rd_data=7.
- Single bank: in SEARCH with in_valid=1 -> in_ready=0, no write; pulse done -> busy=0, in_ready=1 next cycle.
- Ping-pong: stream 32 samples (frame A = 4'h3 repeated, frame B = 4'hC repeated) with done withheld -> all 32 accepted, then in_ready=0. Pulse done -> rd_data = 4'hC at any rd_addr, and a second start one cycle later.
- Backpressure: toggle in_valid every other cycle for a frame -> exactly 16 writes, in order; start only after the 16th.
- Assert reset after 9 samples -> in_ready=1, no start; a fresh 16-sample frame then produces exactly one start.
- done during IDLE -> no state change, no start, full flags unchanged.

Source files
------------

// File: rtl/maxfinder_pkg.sv
// maxfinder_loader shared definitions
// Default widths, frame length and search-state encoding.
package maxfinder_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int AW_DEF = 4;
  localparam logic [3:0] LASTADDR_DEF = 4'hf;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

endpackage

// File: rtl/maxfinder_sample_ram.sv
// maxfinder sample register file
// One synchronous write port, one combinational read port.
module maxfinder_sample_ram #(
  parameter int WIDTH = 4,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  // sample storage, contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxfinder_loader.sv
// maxfinder_loader: fills sample frames and hands them to the searcher.
// Define MAXFINDER_LOADER_PINGPONG_EN for two banks (fill while searching).
module maxfinder_loader
  import maxfinder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW = AW_DEF,
  parameter logic [AW-1:0] LASTADDR = AW'(LASTADDR_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             start,
  input  logic             done,
  output logic             busy
);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          accept;
  logic          last;
  logic          release_bank;
  logic          rd_full;

  assign accept = in_valid && in_ready;
  assign last = accept && (wr_ptr == LASTADDR);
  assign busy = (state == SEARCH);
  assign release_bank = busy && done;

  // write pointer walks the frame and wraps after the last address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= last ? '0 : wr_ptr + 1'b1;
    end
  end

`ifdef MAXFINDER_LOADER_PINGPONG_EN

  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic [WIDTH-1:0] rd_data0;
  logic [WIDTH-1:0] rd_data1;

  assign in_ready = !full[wr_bank];
  assign rd_full = full[rd_bank];
  assign rd_data = rd_bank ? rd_data1 : rd_data0;

  // bank ownership: writer marks a bank full, searcher frees it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (last) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

  maxfinder_sample_ram #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram0 (
    .clk    (clk),
    .we     (accept && !wr_bank),
    .wr_addr(wr_ptr),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data0)
  );

  maxfinder_sample_ram #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram1 (
    .clk    (clk),
    .we     (accept && wr_bank),
    .wr_addr(wr_ptr),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data1)
  );

`else

  logic full;

  assign in_ready = !full;
  assign rd_full = full;

  // single bank: held full from frame completion until the search ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
    end else if (last) begin
      full <= 1'b1;
    end else if (release_bank) begin
      full <= 1'b0;
    end
  end

  maxfinder_sample_ram #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .we     (accept),
    .wr_addr(wr_ptr),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

`endif

  // search FSM with a registered one-cycle start pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      start <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_full) begin
            state <= SEARCH;
            start <= 1'b1;
          end else begin
            start <= 1'b0;
          end
        end
        SEARCH: begin
          start <= 1'b0;
          if (done) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule
